// File: rtl/alu_pipe_core.sv
// Handshaked four-unit ALU (arith/logic/shift/cmp) with an iterative restoring divider.
// Latency: 1 cycle for every op except divide with B!=0, which takes WIDTH+1 cycles.
// Backpressure: IN_READY drops while the divider iterates; there is no output backpressure.
module alu_pipe_core #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [3:0]         ALU_FUNC,
    output logic               OUT_VALID,
    output logic [2*WIDTH-1:0] RESULT,
    output logic [3:0]         UNIT_FLAG,
    output logic               CARRY,
    output logic               OVF,
    output logic               ZERO,
    output logic               DIV0
);

    localparam int W2    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] div_rem_q;
    logic [WIDTH-1:0] div_quo_q;
    logic [WIDTH-1:0] div_dsr_q;
    logic [CNT_W-1:0] div_cnt_q;

    logic accept;
    logic is_div;
    logic b_zero;
    logic start_div;
    logic div_last;

    assign IN_READY  = (state_q == IDLE);
    assign accept    = IN_VALID && IN_READY;
    assign is_div    = (ALU_FUNC == 4'b0011);
    assign b_zero    = (B == '0);
    assign start_div = accept && is_div && !b_zero;
    assign div_last  = (div_cnt_q == CNT_W'(1));

    // ---------------------------------------------------------------
    // Single-cycle units
    // ---------------------------------------------------------------
    logic [W2-1:0]      a_sx, b_sx;
    logic [W2-1:0]      add_full, sub_full, mul_full;
    logic [WIDTH:0]     add_u, sub_u;
    logic               add_ovf, sub_ovf;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   sra_res;
    logic [W2-1:0]      rot_dbl;
    logic               a_eq_b, a_gt_b, a_lt_b;

    assign a_sx = {{WIDTH{A[WIDTH-1]}}, A};
    assign b_sx = {{WIDTH{B[WIDTH-1]}}, B};

    // Full-precision signed results; the WIDTH+1 unsigned sums only feed CARRY/OVF.
    assign add_full = a_sx + b_sx;
    assign sub_full = a_sx - b_sx;
    assign mul_full = a_sx * b_sx;
    assign add_u    = {1'b0, A} + {1'b0, B};
    assign sub_u    = {1'b0, A} - {1'b0, B};
    assign add_ovf  = (A[WIDTH-1] == B[WIDTH-1]) && (add_u[WIDTH-1] != A[WIDTH-1]);
    assign sub_ovf  = (A[WIDTH-1] != B[WIDTH-1]) && (sub_u[WIDTH-1] != A[WIDTH-1]);

    assign shamt   = B[SHAMT_W-1:0];
    assign sra_res = $signed(A) >>> shamt;
    // Upper half of {A,A} shifted left is A rotated left by shamt.
    assign rot_dbl = {A, A} << shamt;

    assign a_eq_b = (A == B);
    assign a_gt_b = ($signed(A) > $signed(B));
    assign a_lt_b = ($signed(A) < $signed(B));

    logic [W2-1:0]    op_res;
    logic [WIDTH-1:0] op_narrow;
    logic             op_carry, op_ovf, op_div0;
    logic [3:0]       op_unit;

    assign op_unit = 4'b0001 << ALU_FUNC[3:2];

    always_comb begin
        op_res    = '0;
        op_narrow = '0;
        op_carry  = 1'b0;
        op_ovf    = 1'b0;
        op_div0   = 1'b0;
        unique case (ALU_FUNC[3:2])
            2'b00: begin
                unique case (ALU_FUNC[1:0])
                    2'b00: begin
                        op_res   = add_full;
                        op_carry = add_u[WIDTH];
                        op_ovf   = add_ovf;
                    end
                    2'b01: begin
                        op_res   = sub_full;
                        op_carry = sub_u[WIDTH];
                        op_ovf   = sub_ovf;
                    end
                    2'b10: op_res = mul_full;
                    default: begin
                        // Only reaches the output path when B is zero.
                        op_res  = {A, {WIDTH{1'b1}}};
                        op_div0 = 1'b1;
                    end
                endcase
            end
            2'b01: begin
                unique case (ALU_FUNC[1:0])
                    2'b00:   op_narrow = A & B;
                    2'b01:   op_narrow = A | B;
                    2'b10:   op_narrow = ~(A & B);
                    default: op_narrow = ~(A | B);
                endcase
                op_res = {{WIDTH{1'b0}}, op_narrow};
            end
            2'b10: begin
                unique case (ALU_FUNC[1:0])
                    2'b00:   op_narrow = A >> shamt;
                    2'b01:   op_narrow = A << shamt;
                    2'b10:   op_narrow = sra_res;
                    default: op_narrow = rot_dbl[W2-1:WIDTH];
                endcase
                op_res = {{WIDTH{1'b0}}, op_narrow};
            end
            default: begin
                unique case (ALU_FUNC[1:0])
                    2'b00:   op_res = a_eq_b ? W2'(1) : '0;
                    2'b01:   op_res = a_gt_b ? W2'(2) : '0;
                    2'b10:   op_res = a_lt_b ? W2'(3) : '0;
                    default: op_res = '0;
                endcase
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Restoring divider step
    // ---------------------------------------------------------------
    logic [WIDTH:0]   trial_rem, trial_diff;
    logic             step_ok;
    logic [WIDTH-1:0] step_rem, step_quo;

    // The partial remainder stays below the divisor, so the trial value fits in WIDTH+1 bits.
    assign trial_rem  = {div_rem_q, div_quo_q[WIDTH-1]};
    assign trial_diff = trial_rem - {1'b0, div_dsr_q};
    assign step_ok    = !trial_diff[WIDTH];
    assign step_rem   = step_ok ? trial_diff[WIDTH-1:0] : trial_rem[WIDTH-1:0];
    assign step_quo   = {div_quo_q[WIDTH-2:0], step_ok};

    // ---------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_div) state_d = BUSY;
            default: if (div_last)  state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath and output registers
    // ---------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div_rem_q <= '0;
            div_quo_q <= '0;
            div_dsr_q <= '0;
            div_cnt_q <= '0;
            OUT_VALID <= 1'b0;
            RESULT    <= '0;
            UNIT_FLAG <= '0;
            CARRY     <= 1'b0;
            OVF       <= 1'b0;
            ZERO      <= 1'b0;
            DIV0      <= 1'b0;
        end else begin
            OUT_VALID <= 1'b0;
            if (state_q == IDLE) begin
                if (start_div) begin
                    div_rem_q <= '0;
                    div_quo_q <= A;
                    div_dsr_q <= B;
                    div_cnt_q <= CNT_W'(WIDTH);
                end else if (accept) begin
                    OUT_VALID <= 1'b1;
                    RESULT    <= op_res;
                    UNIT_FLAG <= op_unit;
                    CARRY     <= op_carry;
                    OVF       <= op_ovf;
                    ZERO      <= (op_res == '0);
                    DIV0      <= op_div0;
                end
            end else begin
                div_rem_q <= step_rem;
                div_quo_q <= step_quo;
                div_cnt_q <= div_cnt_q - CNT_W'(1);
                if (div_last) begin
                    OUT_VALID <= 1'b1;
                    RESULT    <= {step_rem, step_quo};
                    UNIT_FLAG <= 4'b0001;
                    CARRY     <= 1'b0;
                    OVF       <= 1'b0;
                    ZERO      <= ({step_rem, step_quo} == '0);
                    DIV0      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe_core.sv
// Directed + randomized bench for alu_pipe_core (WIDTH=16) with a reference model and
// an expected-result queue drained whenever OUT_VALID is seen.
module tb_alu_pipe_core;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [3:0]  ALU_FUNC = '0;
    logic        OUT_VALID;
    logic [31:0] RESULT;
    logic [3:0]  UNIT_FLAG;
    logic        CARRY, OVF, ZERO, DIV0;

    alu_pipe_core #(.WIDTH(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .ALU_FUNC  (ALU_FUNC),
        .OUT_VALID (OUT_VALID),
        .RESULT    (RESULT),
        .UNIT_FLAG (UNIT_FLAG),
        .CARRY     (CARRY),
        .OVF       (OVF),
        .ZERO      (ZERO),
        .DIV0      (DIV0)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  unit;
        logic        carry;
        logic        ovf;
        logic        zero;
        logic        div0;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_out  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        exp_t   e;
        longint sa, sb, ua, ub, r;
        int     s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        s  = int'(b[3:0]);
        r  = 0;
        e  = '0;
        e.unit = 4'b0001 << f[3:2];
        case (f)
            4'h0: begin
                r = sa + sb;
                e.carry = (ua + ub) > 65535;
                e.ovf   = (r > 32767) || (r < -32768);
            end
            4'h1: begin
                r = sa - sb;
                e.carry = ua < ub;
                e.ovf   = (r > 32767) || (r < -32768);
            end
            4'h2: r = sa * sb;
            4'h3: begin
                if (ub == 0) begin
                    r = (ua << 16) | 65535;
                    e.div0 = 1'b1;
                end else begin
                    r = ((ua % ub) << 16) | (ua / ub);
                end
            end
            4'h4: r = ua & ub;
            4'h5: r = ua | ub;
            4'h6: r = ~(ua & ub) & 65535;
            4'h7: r = ~(ua | ub) & 65535;
            4'h8: r = ua >> s;
            4'h9: r = (ua << s) & 65535;
            4'hA: r = (sa >>> s) & 65535;
            4'hB: r = ((ua << s) | (ua >> (16 - s))) & 65535;
            4'hC: r = (sa == sb) ? 1 : 0;
            4'hD: r = (sa > sb) ? 2 : 0;
            4'hE: r = (sa < sb) ? 3 : 0;
            default: r = 0;
        endcase
        e.res  = r[31:0];
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // Offer an op; it is expected only if the core is ready in this cycle.
    task automatic drive(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        IN_VALID = 1'b1;
        ALU_FUNC = f;
        A = a;
        B = b;
        if (IN_READY) exp_q.push_back(model(f, a, b));
    endtask

    task automatic tick();
        exp_t e, o;
        @(posedge CLK);
        #1;
        if (OUT_VALID) begin
            n_out++;
            if (exp_q.size() == 0) begin
                chk("spurious_out", 64'(OUT_VALID), 64'd0);
            end else begin
                e = exp_q.pop_front();
                o = {RESULT, UNIT_FLAG, CARRY, OVF, ZERO, DIV0};
                chk("scoreboard", 64'(o), 64'(e));
            end
        end
    endtask

    initial begin
        int lat;
        int out_before;
        logic [3:0]  rf;
        logic [15:0] ra, rb;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready",  64'(IN_READY),  64'd1);
        chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
        chk("rst_result",    64'(RESULT),    64'd0);
        chk("rst_unit_flag", 64'(UNIT_FLAG), 64'd0);
        chk("rst_flags",     64'({CARRY, OVF, ZERO, DIV0}), 64'd0);
        RST = 1'b1;
        tick();

        // Add with signed overflow
        drive(4'b0000, 16'h7FFF, 16'h0001);
        tick();
        IN_VALID = 1'b0;
        chk("add_out_valid", 64'(OUT_VALID), 64'd1);
        chk("add_result",    64'(RESULT),    64'h0000_8000);
        chk("add_ovf",       64'(OVF),       64'd1);
        chk("add_carry",     64'(CARRY),     64'd0);
        chk("add_unit_flag", 64'(UNIT_FLAG), 64'b0001);
        tick();
        chk("add_single_pulse", 64'(OUT_VALID), 64'd0);

        // Back-to-back mul then sub
        drive(4'b0010, 16'hFFFD, 16'h0005);
        tick();
        chk("mul_out_valid", 64'(OUT_VALID), 64'd1);
        chk("mul_result",    64'(RESULT),    64'hFFFF_FFF1);
        drive(4'b0001, 16'h0001, 16'h0002);
        tick();
        IN_VALID = 1'b0;
        chk("sub_out_valid", 64'(OUT_VALID), 64'd1);
        chk("sub_result",    64'(RESULT),    64'hFFFF_FFFF);
        chk("sub_carry",     64'(CARRY),     64'd1);
        chk("sub_zero",      64'(ZERO),      64'd0);
        tick();

        // Divide 100/7 with dropped IN_VALID pulses during busy
        drive(4'b0011, 16'd100, 16'd7);
        tick();
        lat = 0;
        while (!OUT_VALID && lat < 40) begin
            chk("div_busy_in_ready", 64'(IN_READY), 64'd0);
            IN_VALID = lat[0];
            ALU_FUNC = 4'($urandom);
            A = 16'($urandom);
            B = 16'($urandom);
            tick();
            lat++;
        end
        IN_VALID = 1'b0;
        chk("div_latency",  64'(lat),      64'd16);
        chk("div_result",   64'(RESULT),   64'h0002_000E);
        chk("div_in_ready", 64'(IN_READY), 64'd1);

        // Op presented in the divide's OUT_VALID cycle: divide by zero
        drive(4'b0011, 16'h1234, 16'h0000);
        tick();
        IN_VALID = 1'b0;
        chk("div0_out_valid", 64'(OUT_VALID), 64'd1);
        chk("div0_result",    64'(RESULT),    64'h1234_FFFF);
        chk("div0_flag",      64'(DIV0),      64'd1);
        chk("div0_in_ready",  64'(IN_READY),  64'd1);
        tick();

        // Shift and compare
        drive(4'b1011, 16'h8001, 16'd4);
        tick();
        chk("rol_result", 64'(RESULT), 64'h0000_0018);
        drive(4'b1010, 16'h8000, 16'd15);
        tick();
        chk("sra_result", 64'(RESULT), 64'h0000_FFFF);
        drive(4'b1110, 16'hFFFF, 16'h0000);
        tick();
        chk("cmp_lt_result",    64'(RESULT),    64'd3);
        chk("cmp_lt_unit_flag", 64'(UNIT_FLAG), 64'b1000);
        drive(4'b0111, 16'hFFFF, 16'h0000);
        tick();
        chk("nor_zero", 64'(ZERO), 64'd1);
        IN_VALID = 1'b0;
        tick();

        // Reset during a divide aborts it
        drive(4'b0011, 16'd1000, 16'd3);
        tick();
        IN_VALID = 1'b0;
        repeat (5) tick();
        out_before = n_out;
        RST = 1'b0;
        #1;
        chk("abort_rst_in_ready",  64'(IN_READY),  64'd1);
        chk("abort_rst_out_valid", 64'(OUT_VALID), 64'd0);
        chk("abort_rst_result",    64'(RESULT),    64'd0);
        exp_q.delete();
        tick();
        tick();
        RST = 1'b1;
        repeat (20) tick();
        chk("abort_no_out",   64'(n_out - out_before), 64'd0);
        chk("abort_in_ready", 64'(IN_READY), 64'd1);
        drive(4'b0100, 16'hF0F0, 16'hFF00);
        tick();
        IN_VALID = 1'b0;
        chk("and_out_valid", 64'(OUT_VALID), 64'd1);
        chk("and_result",    64'(RESULT),    64'h0000_F000);
        tick();

        // Random traffic, including divides that stall the stream
        for (int i = 0; i < 120; i++) begin
            rf = 4'($urandom);
            ra = 16'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
            drive(rf, ra, rb);
            tick();
        end
        IN_VALID = 1'b0;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
